// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
// Holds the loader FSM state type, error codes, opcode field position and
// the legal-opcode set. The decode stage (main_decoder) imports the same
// LEGAL_OPCODES list so the loader and decoder agree on what is legal.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LEN      = 2'd1;
  localparam logic [1:0] ERR_OPCODE   = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;

  localparam int unsigned N_LEGAL = 10;
  localparam logic [5:0] LEGAL_OPCODES [N_LEGAL] = '{
    6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
    6'h05, 6'h06, 6'h07, 6'h08, 6'h09
  };

  function automatic logic opcode_legal(input logic [5:0] opc);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL; i++) begin
      if (LEGAL_OPCODES[i] == opc) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, instruction-memory write bus and
// loader status, bundled for the loader.
//   slave  : loader side (takes start/byte stream, drives everything else)
//   master : host/system side
// Signals: start, byte_valid, byte_data[7:0], byte_ready, imem_we,
//   imem_addr[AW-1:0], imem_wdata[31:0], cpu_rst_hold, busy, done, error,
//   err_code[1:0], word_count[AW:0].
interface imem_loader_if #(
  parameter int unsigned AW = 8
);
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_hold,
           busy, done, error, err_code, word_count
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_hold,
           busy, done, error, err_code, word_count
  );
endinterface

// File: rtl/imem_loader_word.sv
// word_assembler: big-endian byte-to-word shift register, byte index and
// running XOR checksum for the loader.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : start of a new session (resets index and checksum)
//   take        : accept byte_data as the next instruction byte
//   byte_data   : incoming byte
//   word_valid  : this take completes a word (combinational)
//   opcode      : opcode field of the word being completed (combinational)
//   word        : registered assembled word
//   checksum    : XOR of all bytes taken this session
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [5:0]  opcode,
  output logic [31:0] word,
  output logic [7:0]  checksum
);

  logic [1:0]  idx;
  logic [31:0] next_word;

  assign next_word  = {word[23:0], byte_data};
  assign word_valid = take && (idx == 2'd3);
  // The FSM must judge the opcode on the same edge the 4th byte arrives,
  // so it sees the word before it lands in the register.
  assign opcode     = next_word[OPC_MSB:OPC_LSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      idx      <= '0;
      checksum <= '0;
    end else if (clear) begin
      idx      <= '0;
      checksum <= '0;
    end else if (take) begin
      word     <= next_word;
      idx      <= idx + 2'd1;
      checksum <= checksum ^ byte_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (LEN_HI, LEN_LO, 4N
// instruction bytes, XOR checksum), validates opcodes, writes words into
// instruction memory and holds the core in reset until a good program is
// loaded.
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem_loader_if.slave (byte stream, imem write port, status)
// Parameters: R (Rd field width), DEPTH (imem words), AW (address width).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned R     = 5,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  // Rd sits directly below the opcode; a wider Rd would overlap it.
  if (R > OPC_LSB) begin : g_bad_r
    $error("imem_loader: Rd width overlaps opcode field");
  end

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [15:0] n_len;
  logic [AW:0] word_count;
  logic        done_q;
  logic        error_q;
  logic [1:0]  err_code_q;
  logic        hold_q;

  logic        accepting;
  logic        xfer;
  logic        start_ok;
  logic        len_bad;
  logic        last_word;
  logic        word_valid;
  logic [5:0]  opcode;
  logic [31:0] word;
  logic [7:0]  checksum;

  assign accepting = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_WORD)   || (state == S_CHECK);
  assign xfer      = bus.byte_valid && accepting;
  assign start_ok  = bus.start &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign n_len     = {len_hi, bus.byte_data};
  assign len_bad   = (n_len == 16'd0) || (32'(n_len) > DEPTH);
  assign last_word = (17'(word_count) + 17'd1) == 17'(n_words);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .take       (xfer && (state == S_WORD)),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid),
    .opcode     (opcode),
    .word       (word),
    .checksum   (checksum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_hi     <= '0;
      n_words    <= '0;
      word_count <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      hold_q     <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state      <= S_LEN_HI;
            word_count <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            hold_q     <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.byte_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            n_words <= n_len;
            if (len_bad) begin
              state      <= S_ERROR;
              error_q    <= 1'b1;
              err_code_q <= ERR_LEN;
            end else begin
              state <= S_WORD;
            end
          end
        end
        S_WORD: begin
          if (word_valid) begin
            if (!opcode_legal(opcode)) begin
              state      <= S_ERROR;
              error_q    <= 1'b1;
              err_code_q <= ERR_OPCODE;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_count <= word_count + 1'b1;
          state      <= last_word ? S_CHECK : S_WORD;
        end
        S_CHECK: begin
          if (xfer) begin
            if (bus.byte_data == checksum) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              state      <= S_ERROR;
              error_q    <= 1'b1;
              err_code_q <= ERR_CHECKSUM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready   = accepting;
  assign bus.busy         = accepting || (state == S_WRITE);
  assign bus.imem_we      = (state == S_WRITE);
  assign bus.imem_addr    = word_count[AW-1:0];
  assign bus.imem_wdata   = word;
  assign bus.cpu_rst_hold = hold_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.err_code     = err_code_q;
  assign bus.word_count   = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames, expected memory
// writes queued by the stimulus and checked by an independent monitor.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   wr_seen = 0;
  wr_t  exp_q[$];
  logic [31:0] frame_words[$];

  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.R(5), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write cycle must match the head of the expectation queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.imem_we === 1'b1) begin
        wr_seen++;
        check("wr_byte_ready_low", 64'(bus.byte_ready), 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
          check("wr_data", 64'(bus.imem_wdata), 64'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    forever begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL byte_timeout: got no byte_ready expected accept of %0h", b);
        break;
      end
    end
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic random_gap(input bit gaps);
    if (gaps) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(1, 0) == 1) step();
      end
    end
  endtask

  function automatic logic [7:0] frame_csum();
    logic [7:0] c;
    c = 8'h00;
    foreach (frame_words[i]) begin
      c = c ^ frame_words[i][31:24] ^ frame_words[i][23:16]
            ^ frame_words[i][15:8]  ^ frame_words[i][7:0];
    end
    return c;
  endfunction

  // Full frame of frame_words; expected writes are queued here at issue time.
  task automatic send_frame(input bit bad_csum, input bit gaps);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(frame_words.size());
    foreach (frame_words[i]) exp_q.push_back('{addr: AW'(i), data: frame_words[i]});
    send_byte(n[15:8]);
    random_gap(gaps);
    send_byte(n[7:0]);
    foreach (frame_words[i]) begin
      w = frame_words[i];
      for (int b = 3; b >= 0; b--) begin
        random_gap(gaps);
        send_byte(w[b*8 +: 8]);
      end
    end
    random_gap(gaps);
    send_byte(bad_csum ? (frame_csum() ^ 8'hFF) : frame_csum());
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic [1:0] code, input logic hold,
                              input logic [AW:0] cnt);
    @(negedge clk);
    check({tag, "_done"},       64'(bus.done), 64'(d));
    check({tag, "_error"},      64'(bus.error), 64'(e));
    check({tag, "_err_code"},   64'(bus.err_code), 64'(code));
    check({tag, "_hold"},       64'(bus.cpu_rst_hold), 64'(hold));
    check({tag, "_word_count"}, 64'(bus.word_count), 64'(cnt));
    check({tag, "_busy"},       64'(bus.busy), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    step();
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                bus.cpu_rst_hold, bus.busy, bus.done, bus.error,
                bus.err_code, bus.word_count});
  endfunction

  localparam logic [63:0] RESET_VEC = 64'({1'b0, 1'b0, 8'h00, 32'h0, 1'b1,
                                           1'b0, 1'b0, 1'b0, 2'd0, 9'd0});

  initial begin
    int w0;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), RESET_VEC);
    step();
    rst = 1'b0;
    step();

    // Good two-word load; a start pulse mid-session must be ignored
    frame_words = '{32'h0420_0000, 32'h0840_0001};
    pulse_start();
    @(negedge clk);
    check("session_busy", 64'(bus.busy), 64'd1);
    step();
    w0 = wr_seen;
    exp_q.push_back('{addr: 8'd0, data: 32'h0420_0000});
    exp_q.push_back('{addr: 8'd1, data: 32'h0840_0001});
    send_byte(8'h00);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h04); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h40); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h6D);
    check_status("good", 1'b1, 1'b0, 2'd0, 1'b0, 9'd2);
    check("good_writes", 64'(wr_seen - w0), 64'd2);

    // Restart from DONE re-asserts hold; zero length rejected
    pulse_start();
    @(negedge clk);
    check("restart_hold", 64'(bus.cpu_rst_hold), 64'd1);
    check("restart_done_clr", 64'(bus.done), 64'd0);
    step();
    w0 = wr_seen;
    send_byte(8'h00);
    send_byte(8'h00);
    check_status("len0", 1'b0, 1'b1, 2'd1, 1'b1, 9'd0);

    // Length DEPTH+1 rejected
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    check_status("len257", 1'b0, 1'b1, 2'd1, 1'b1, 9'd0);
    check("len_err_writes", 64'(wr_seen - w0), 64'd0);

    // Illegal opcode 0x3F: no write
    w0 = wr_seen;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_status("bad_opc", 1'b0, 1'b1, 2'd2, 1'b1, 9'd0);
    check("bad_opc_writes", 64'(wr_seen - w0), 64'd0);

    // Checksum mismatch after both words are written
    w0 = wr_seen;
    pulse_start();
    exp_q.push_back('{addr: 8'd0, data: 32'h0420_0000});
    exp_q.push_back('{addr: 8'd1, data: 32'h0840_0001});
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h04); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h40); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00);
    check_status("bad_csum", 1'b0, 1'b1, 2'd3, 1'b1, 9'd2);
    check("bad_csum_writes", 64'(wr_seen - w0), 64'd2);

    // Three words with random byte_valid gaps
    frame_words = '{32'h0C60_0002, 32'h10A0_0003, 32'h14E0_FFFF};
    pulse_start();
    send_frame(1'b0, 1'b1);
    check_status("gaps", 1'b1, 1'b0, 2'd0, 1'b0, 9'd3);

    // Full-depth load: last address 255, word_count 256
    frame_words.delete();
    for (int i = 0; i < int'(DEPTH); i++) frame_words.push_back(32'h2000_0000 | 32'(i * 7));
    pulse_start();
    send_frame(1'b0, 1'b0);
    check_status("full_depth", 1'b1, 1'b0, 2'd0, 1'b0, 9'd256);

    // Reset mid-word, then a clean reload from address 0
    w0 = wr_seen;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h04); send_byte(8'hAB);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midword_reset", out_vec(), RESET_VEC);
    step();
    rst = 1'b0;
    step();
    check("midword_writes", 64'(wr_seen - w0), 64'd0);
    frame_words = '{32'h0123_4567};
    pulse_start();
    send_frame(1'b0, 1'b0);
    check_status("reload", 1'b1, 1'b0, 2'd0, 1'b0, 9'd1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
